// File: rtl/spi_pkg.sv
// Shared constants and types for the single-byte SPI master.
package spi_pkg;

  localparam int WORD_W = 8;

  // Bit positions on the uio bus
  localparam int UIO_START = 0;
  localparam int UIO_MISO  = 1;
  localparam int UIO_SCLK  = 2;
  localparam int UIO_MOSI  = 3;
  localparam int UIO_CSN   = 4;
  localparam int UIO_BUSY  = 5;
  localparam int UIO_DONE  = 6;

  // Bits 2..6 drive out; START and MISO (0, 1) and bit 7 stay inputs
  localparam logic [7:0] UIO_OE = 8'h7C;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_master_core.sv
// SPI mode 0 byte engine, MSB first, SCLK = clk/2.
//
// state | meaning
// IDLE  | waiting for a rising edge on start; CS_n high
// XFER  | shifting 8 bits; phase 0 raises SCLK, phase 1 lowers it
module spi_master_core
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_data
);

  spi_state_t        state;
  logic              start_q;
  logic              phase;
  logic [2:0]        count;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] rx_shift;

  // Start edge detect, transfer sequencing and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      phase    <= 1'b0;
      count    <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      // start_q tracks the pin even while busy so a held start never retriggers
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[WORD_W-1];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            sclk     <= 1'b0;
            count    <= 3'd7;
            phase    <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (!phase) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[WORD_W-2:0], miso};
            phase    <= 1'b1;
          end else begin
            sclk  <= 1'b0;
            phase <= 1'b0;
            if (count == 3'd0) begin
              // Last bit was captured on the preceding rising half
              cs_n    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_shift;
              state   <= IDLE;
            end else begin
              tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
              mosi     <= tx_shift[WORD_W-2];
              count    <= count - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_spi_master.sv
// Tiny Tapeout pin wrapper around the SPI master core.
module tt_um_spi_master
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic sclk;
  logic mosi;
  logic cs_n;
  logic busy;
  logic done;
  logic unused_pins;

  spi_master_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (uio_in[UIO_START]),
    .tx_data (ui_in),
    .miso    (uio_in[UIO_MISO]),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .busy    (busy),
    .done    (done),
    .rx_data (uo_out)
  );

  // Map core outputs onto the fixed uio bit positions; unused bits read 0
  always_comb begin
    uio_out           = '0;
    uio_out[UIO_SCLK] = sclk;
    uio_out[UIO_MOSI] = mosi;
    uio_out[UIO_CSN]  = cs_n;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_DONE] = done;
  end

  assign uio_oe = UIO_OE;

  // ena and the upper uio inputs carry no function
  assign unused_pins = &{1'b0, ena, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_spi_master.sv
// Directed bench for tt_um_spi_master with a done-triggered scoreboard.
module tb_tt_um_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       start_drv;
  logic       loopback;
  logic [7:0] miso_byte;
  logic [2:0] miso_idx;
  logic       miso_bit;

  int         checks;
  int         failures;
  int         sclk_rises;
  int         cs_low_cycles;
  int         done_cnt;
  logic [7:0] mosi_bits;
  logic       mosi_zero_seen;
  logic       sclk_prev;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign miso_bit = loopback ? uio_out[3] : miso_byte[miso_idx];
  assign uio_in   = {6'b0, miso_bit, start_drv};

  tt_um_spi_master dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_counters();
    sclk_rises     = 0;
    cs_low_cycles  = 0;
    done_cnt       = 0;
    mosi_bits      = 8'h00;
    mosi_zero_seen = 1'b0;
  endtask

  task automatic wait_done(input int n, input string name);
    int i;
    i = 0;
    while (done_cnt < n && i < 60) begin
      tick();
      i++;
    end
    check(name, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic pulse_start(input int width);
    start_drv = 1'b1;
    tick(width);
    start_drv = 1'b0;
  endtask

  // Line activity monitor: SCLK edges, CS_n low time, MOSI capture, MISO pattern
  initial begin
    sclk_prev = 1'b0;
    miso_idx  = 3'd7;
    forever begin
      @(negedge clk);
      if (uio_out[4]) begin
        miso_idx = 3'd7;
      end else begin
        cs_low_cycles++;
        if (!uio_out[3]) mosi_zero_seen = 1'b1;
        if (sclk_prev && !uio_out[2]) miso_idx = miso_idx - 3'd1;
      end
      if (!sclk_prev && uio_out[2]) begin
        sclk_rises++;
        mosi_bits = {mosi_bits[6:0], uio_out[3]};
      end
      if (uio_out[6]) done_cnt++;
      sclk_prev = uio_out[2];
    end
  end

  // Scoreboard: every done pulse must match the oldest expected byte
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (uio_out[6]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done uo_out=%h expected=none", uo_out);
        end else begin
          exp = exp_q.pop_front();
          check("rx_byte", 32'(uo_out), 32'(exp));
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ena       = 1'b1;
    ui_in     = 8'h00;
    start_drv = 1'b0;
    loopback  = 1'b1;
    miso_byte = 8'h00;
    clr_counters();

    // Reset values, then hold while idle
    tick(2);
    check("reset_uo_out", 32'(uo_out), 32'h00);
    check("reset_uio_out", 32'(uio_out), 32'h10);
    check("reset_uio_oe", 32'(uio_oe), 32'h7C);
    rst = 1'b0;
    tick(5);
    check("idle_uo_out", 32'(uo_out), 32'h00);
    check("idle_uio_out", 32'(uio_out), 32'h10);
    check("idle_uio_oe", 32'(uio_oe), 32'h7C);

    // Loopback 0x53 with a 2-cycle start
    clr_counters();
    ui_in = 8'h53;
    exp_q.push_back(8'h53);
    pulse_start(2);
    wait_done(1, "lb_done_timeout");
    check("lb_mosi_bits", 32'(mosi_bits), 32'h53);
    check("lb_sclk_pulses", 32'(sclk_rises), 32'd8);
    check("lb_cs_low_cycles", 32'(cs_low_cycles), 32'd16);
    tick(3);
    check("lb_done_count", 32'(done_cnt), 32'd1);
    check("lb_uo_out_hold", 32'(uo_out), 32'h53);

    // MISO pattern 0xA5 with all-ones transmit
    clr_counters();
    loopback  = 1'b0;
    miso_byte = 8'hA5;
    ui_in     = 8'hFF;
    exp_q.push_back(8'hA5);
    pulse_start(1);
    wait_done(1, "a5_done_timeout");
    check("a5_mosi_zero_seen", 32'(mosi_zero_seen), 32'd0);
    check("a5_sclk_pulses", 32'(sclk_rises), 32'd8);
    tick(2);
    loopback = 1'b1;

    // Start held high for 40 cycles gives one transfer; a new edge gives another
    clr_counters();
    ui_in = 8'h11;
    exp_q.push_back(8'h11);
    pulse_start(40);
    check("held_done_count", 32'(done_cnt), 32'd1);
    check("held_sclk_pulses", 32'(sclk_rises), 32'd8);
    clr_counters();
    tick(1);
    ui_in = 8'h22;
    exp_q.push_back(8'h22);
    pulse_start(1);
    wait_done(1, "rearm_done_timeout");
    check("rearm_sclk_pulses", 32'(sclk_rises), 32'd8);
    tick(2);

    // Start pulse during a transfer is ignored
    clr_counters();
    ui_in = 8'h96;
    exp_q.push_back(8'h96);
    pulse_start(1);
    tick(4);
    ui_in = 8'h00;
    pulse_start(1);
    wait_done(1, "busy_done_timeout");
    tick(20);
    check("busy_sclk_pulses", 32'(sclk_rises), 32'd8);
    check("busy_done_count", 32'(done_cnt), 32'd1);
    check("busy_uo_out", 32'(uo_out), 32'h96);

    // Reset mid-transfer aborts without a done pulse
    clr_counters();
    ui_in = 8'h3C;
    pulse_start(1);
    tick(8);
    check("abort_busy_before", 32'(uio_out[5]), 32'd1);
    rst = 1'b1;
    tick(1);
    check("abort_uio_out", 32'(uio_out), 32'h10);
    check("abort_uo_out", 32'(uo_out), 32'h00);
    rst = 1'b0;
    tick(30);
    check("abort_done_count", 32'(done_cnt), 32'd0);

    // Fresh transfer after the abort
    clr_counters();
    exp_q.push_back(8'h3C);
    pulse_start(1);
    wait_done(1, "post_abort_done_timeout");
    check("post_abort_mosi_bits", 32'(mosi_bits), 32'h3C);
    tick(3);
    check("post_abort_uo_out", 32'(uo_out), 32'h3C);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
